// File: rtl/tx_resp_arbiter_pkg.sv
// rtl/tx_resp_arbiter_pkg.sv - shared state encoding and frame byte counts for tx_resp_arbiter
package tx_resp_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_REG = 2'd1,
        SEND_LO  = 2'd2,
        SEND_HI  = 2'd3
    } state_t;

    // Bytes written to the TX FIFO per accepted frame
    localparam logic [1:0] REG_FRAME_BYTES = 2'd1;
    localparam logic [1:0] ALU_FRAME_BYTES = 2'd2;
    localparam logic [1:0] ALU_SKIP_BYTES  = 2'd1;

    localparam int GNT_REG = 0;
    localparam int GNT_ALU = 1;

endpackage

// File: rtl/tx_resp_arbiter_rr_arb2.sv
// rtl/tx_resp_arbiter_rr_arb2.sv - two-way round-robin arbiter (rr_arb2), pointer favours the loser of the last grant
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // ptr low favours req[0], high favours req[1]
    logic ptr;

    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] |  ptr);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/tx_resp_arbiter.sv
// rtl/tx_resp_arbiter.sv - arbitrates register-read and ALU responses into TX FIFO bytes; ALU_HI_SKIP_EN drops a zero high byte
module tx_resp_arbiter
    import tx_resp_arbiter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REG_VLD,
    input  logic [DATA_W-1:0]   REG_DATA,
    output logic                REG_RDY,
    input  logic                ALU_VLD,
    input  logic [2*DATA_W-1:0] ALU_DATA,
    output logic                ALU_RDY,
    input  logic                FIFO_FULL,
    output logic [DATA_W-1:0]   WR_DATA,
    output logic                WR_INC,
    output logic                BUSY
);

    state_t              state;
    logic [2*DATA_W-1:0] hold;
    logic [1:0]          frame_len;
    logic [1:0]          alu_len;
    logic                accept_en;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [DATA_W-1:0]   wr_byte;

    // Grants only happen in IDLE and never while reset is asserted
    assign accept_en = RST && (state == IDLE);
    assign req       = {ALU_VLD, REG_VLD} & {2{accept_en}};

    rr_arb2 u_rr_arb2 (
        .clk    (CLK),
        .resetn (RST),
        .req    (req),
        .update (|gnt),
        .gnt    (gnt)
    );

    assign REG_RDY = gnt[GNT_REG];
    assign ALU_RDY = gnt[GNT_ALU];

`ifdef ALU_HI_SKIP_EN
    assign alu_len = (ALU_DATA[2*DATA_W-1:DATA_W] == '0) ? ALU_SKIP_BYTES : ALU_FRAME_BYTES;
`else
    assign alu_len = ALU_FRAME_BYTES;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            hold      <= '0;
            frame_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt[GNT_REG]) begin
                        hold      <= {{DATA_W{1'b0}}, REG_DATA};
                        frame_len <= REG_FRAME_BYTES;
                        state     <= SEND_REG;
                    end else if (gnt[GNT_ALU]) begin
                        hold      <= ALU_DATA;
                        frame_len <= alu_len;
                        state     <= SEND_LO;
                    end
                end
                SEND_REG: begin
                    if (!FIFO_FULL) begin
                        state <= IDLE;
                    end
                end
                SEND_LO: begin
                    // A one-byte ALU frame ends here instead of visiting SEND_HI
                    if (!FIFO_FULL) begin
                        state <= (frame_len == ALU_SKIP_BYTES) ? IDLE : SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (!FIFO_FULL) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_byte = '0;
        case (state)
            SEND_REG, SEND_LO: wr_byte = hold[DATA_W-1:0];
            SEND_HI:           wr_byte = hold[2*DATA_W-1:DATA_W];
            default:           wr_byte = '0;
        endcase
    end

    assign WR_INC  = RST && (state != IDLE) && !FIFO_FULL;
    assign WR_DATA = WR_INC ? wr_byte : '0;
    assign BUSY    = (state != IDLE);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// tb/tb_tx_resp_arbiter.sv - self-checking bench for tx_resp_arbiter with directed scenarios and a queue-based reference model
module tb_tx_resp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_vld;
    logic [7:0]  reg_data;
    logic        reg_rdy;
    logic        alu_vld;
    logic [15:0] alu_data;
    logic        alu_rdy;
    logic        fifo_full;
    logic [7:0]  wr_data;
    logic        wr_inc;
    logic        busy;

    int tests = 0;
    int fails = 0;

    tx_resp_arbiter #(.DATA_W(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .REG_VLD   (reg_vld),
        .REG_DATA  (reg_data),
        .REG_RDY   (reg_rdy),
        .ALU_VLD   (alu_vld),
        .ALU_DATA  (alu_data),
        .ALU_RDY   (alu_rdy),
        .FIFO_FULL (fifo_full),
        .WR_DATA   (wr_data),
        .WR_INC    (wr_inc),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; reg_vld = 1'b0; alu_vld = 1'b0; fifo_full = 1'b0;
        reg_data = 8'h00; alu_data = 16'h0000;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; reg_vld = 1'b1; alu_vld = 1'b1; reg_data = 8'h5A; alu_data = 16'h1234; fifo_full = 1'b0;
        next_cycle();
        #1;
        tests++; if (reg_rdy !== 1'b0) begin fails++; $display("FAIL reset_reg_rdy: got %b expected 0", reg_rdy); end
        tests++; if (alu_rdy !== 1'b0) begin fails++; $display("FAIL reset_alu_rdy: got %b expected 0", alu_rdy); end
        tests++; if (wr_inc !== 1'b0) begin fails++; $display("FAIL reset_wr_inc: got %b expected 0", wr_inc); end
        tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        do_reset();
    endtask

    task automatic test_reg_only();
        do_reset();
        reg_vld = 1'b1; reg_data = 8'h5A;
        #1;
        tests++; if (reg_rdy !== 1'b1) begin fails++; $display("FAIL reg_rdy: got %b expected 1", reg_rdy); end
        tests++; if (wr_inc !== 1'b0) begin fails++; $display("FAIL reg_wr_early: got %b expected 0", wr_inc); end
        next_cycle();
        reg_vld = 1'b0;
        #1;
        tests++; if (wr_inc !== 1'b1) begin fails++; $display("FAIL reg_wr_inc: got %b expected 1", wr_inc); end
        tests++; if (wr_data !== 8'h5A) begin fails++; $display("FAIL reg_wr_data: got %h expected 5a", wr_data); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reg_busy: got %b expected 1", busy); end
        next_cycle();
        #1;
        tests++; if (wr_inc !== 1'b0) begin fails++; $display("FAIL reg_idle_wr: got %b expected 0", wr_inc); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reg_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_alu();
        do_reset();
        alu_vld = 1'b1; alu_data = 16'h1234;
        #1;
        tests++; if (alu_rdy !== 1'b1) begin fails++; $display("FAIL alu_rdy: got %b expected 1", alu_rdy); end
        next_cycle();
        alu_vld = 1'b0; reg_vld = 1'b1; reg_data = 8'hA5;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'h34}) begin fails++; $display("FAIL alu_lo: got %b/%h expected 1/34", wr_inc, wr_data); end
        tests++; if (reg_rdy !== 1'b0) begin fails++; $display("FAIL alu_no_interleave: got %b expected 0", reg_rdy); end
        next_cycle();
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'h12}) begin fails++; $display("FAIL alu_hi: got %b/%h expected 1/12", wr_inc, wr_data); end
        tests++; if (reg_rdy !== 1'b0) begin fails++; $display("FAIL alu_last_no_grant: got %b expected 0", reg_rdy); end
        next_cycle();
        #1;
        tests++; if ({reg_rdy, wr_inc, wr_data} !== {1'b1, 1'b0, 8'h00}) begin fails++; $display("FAIL alu_then_reg: got %b/%b/%h expected 1/0/00", reg_rdy, wr_inc, wr_data); end
        next_cycle();
        reg_vld = 1'b0;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'hA5}) begin fails++; $display("FAIL alu_then_reg_wr: got %b/%h expected 1/a5", wr_inc, wr_data); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [6:0] exp_reg_rdy;
        logic [6:0] exp_alu_rdy;
        logic [6:0] exp_wr;
        logic [7:0] exp_byte [7];
        exp_reg_rdy = 7'b0100001;
        exp_alu_rdy = 7'b0000100;
        exp_wr      = 7'b1011010;
        exp_byte    = '{8'h00, 8'h5A, 8'h00, 8'h34, 8'h12, 8'h00, 8'h5A};
        do_reset();
        reg_vld = 1'b1; reg_data = 8'h5A; alu_vld = 1'b1; alu_data = 16'h1234;
        for (int c = 0; c < 7; c++) begin
            #1;
            tests++; if ({reg_rdy, alu_rdy} !== {exp_reg_rdy[c], exp_alu_rdy[c]}) begin fails++; $display("FAIL contention_grant c%0d: got %b%b expected %b%b", c, reg_rdy, alu_rdy, exp_reg_rdy[c], exp_alu_rdy[c]); end
            tests++; if ({wr_inc, wr_data} !== {exp_wr[c], exp_byte[c]}) begin fails++; $display("FAIL contention_write c%0d: got %b/%h expected %b/%h", c, wr_inc, wr_data, exp_wr[c], exp_byte[c]); end
            next_cycle();
        end
        reg_vld = 1'b0; alu_vld = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        alu_vld = 1'b1; alu_data = 16'h1234;
        #1;
        tests++; if (alu_rdy !== 1'b1) begin fails++; $display("FAIL bp_rdy: got %b expected 1", alu_rdy); end
        next_cycle();
        alu_vld = 1'b0;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'h34}) begin fails++; $display("FAIL bp_lo: got %b/%h expected 1/34", wr_inc, wr_data); end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            fifo_full = 1'b1;
            #1;
            tests++; if ({wr_inc, wr_data, busy} !== {1'b0, 8'h00, 1'b1}) begin fails++; $display("FAIL bp_hold c%0d: got %b/%h/%b expected 0/00/1", c, wr_inc, wr_data, busy); end
        end
        next_cycle();
        fifo_full = 1'b0;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'h12}) begin fails++; $display("FAIL bp_hi: got %b/%h expected 1/12", wr_inc, wr_data); end
        next_cycle();
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_done: got %b expected 0", busy); end
    endtask

    task automatic test_skip();
        logic       exp_second;
        logic [7:0] exp_second_byte;
`ifdef ALU_HI_SKIP_EN
        exp_second = 1'b0;
`else
        exp_second = 1'b1;
`endif
        exp_second_byte = 8'h00;
        do_reset();
        alu_vld = 1'b1; alu_data = 16'h0007;
        #1;
        tests++; if (alu_rdy !== 1'b1) begin fails++; $display("FAIL skip_rdy: got %b expected 1", alu_rdy); end
        next_cycle();
        alu_vld = 1'b0;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'h07}) begin fails++; $display("FAIL skip_lo: got %b/%h expected 1/07", wr_inc, wr_data); end
        next_cycle();
        #1;
        tests++; if ({wr_inc, wr_data, busy} !== {exp_second, exp_second_byte, exp_second}) begin fails++; $display("FAIL skip_hi: got %b/%h/%b expected %b/%h/%b", wr_inc, wr_data, busy, exp_second, exp_second_byte, exp_second); end
        next_cycle();
        #1;
        tests++; if (wr_inc !== 1'b0) begin fails++; $display("FAIL skip_end: got %b expected 0", wr_inc); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        alu_vld = 1'b1; alu_data = 16'h1234;
        #1;
        tests++; if (alu_rdy !== 1'b1) begin fails++; $display("FAIL rmid_rdy: got %b expected 1", alu_rdy); end
        next_cycle();
        alu_vld = 1'b0;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'h34}) begin fails++; $display("FAIL rmid_lo: got %b/%h expected 1/34", wr_inc, wr_data); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        #1;
        tests++; if ({wr_inc, busy, wr_data} !== {1'b0, 1'b0, 8'h00}) begin fails++; $display("FAIL rmid_discard: got %b/%b/%h expected 0/0/00", wr_inc, busy, wr_data); end
        next_cycle();
        #1;
        tests++; if (wr_inc !== 1'b0) begin fails++; $display("FAIL rmid_quiet: got %b expected 0", wr_inc); end
        reg_vld = 1'b1; reg_data = 8'h5A;
        #1;
        tests++; if (reg_rdy !== 1'b1) begin fails++; $display("FAIL rmid_reg_rdy: got %b expected 1", reg_rdy); end
        next_cycle();
        reg_vld = 1'b0; rst = 1'b0;
        next_cycle();
        rst = 1'b1; reg_vld = 1'b1; reg_data = 8'hC3; alu_vld = 1'b1; alu_data = 16'h1234;
        #1;
        tests++; if ({reg_rdy, alu_rdy} !== 2'b10) begin fails++; $display("FAIL rmid_ptr_reset: got %b%b expected 10", reg_rdy, alu_rdy); end
        next_cycle();
        reg_vld = 1'b0; alu_vld = 1'b0;
        #1;
        tests++; if ({wr_inc, wr_data} !== {1'b1, 8'hC3}) begin fails++; $display("FAIL rmid_after: got %b/%h expected 1/c3", wr_inc, wr_data); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic       last_was_reg;
        logic       exp_reg_rdy;
        logic       exp_alu_rdy;
        logic       exp_wr;
        logic [7:0] exp_byte;
        logic       exp_busy;
        logic       reg_done;
        logic       alu_done;
        logic       two_bytes;
        do_reset();
        exp_q.delete();
        last_was_reg = 1'b0;
        reg_done = 1'b0;
        alu_done = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (reg_done) reg_vld = 1'b0;
            if (alu_done) alu_vld = 1'b0;
            if (!reg_vld && $urandom_range(0, 2) == 0) begin
                reg_vld = 1'b1; reg_data = 8'($urandom);
            end
            if (!alu_vld && $urandom_range(0, 2) == 0) begin
                alu_vld = 1'b1;
                alu_data[7:0]  = 8'($urandom);
                alu_data[15:8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;
            exp_busy    = (exp_q.size() != 0);
            exp_reg_rdy = !exp_busy && reg_vld && (!alu_vld || !last_was_reg);
            exp_alu_rdy = !exp_busy && alu_vld && (!reg_vld || last_was_reg);
            exp_wr      = exp_busy && !fifo_full;
            exp_byte    = exp_wr ? exp_q[0] : 8'h00;
            tests++; if (reg_rdy !== exp_reg_rdy) begin fails++; $display("FAIL rand_reg_rdy c%0d: got %b expected %b", c, reg_rdy, exp_reg_rdy); end
            tests++; if (alu_rdy !== exp_alu_rdy) begin fails++; $display("FAIL rand_alu_rdy c%0d: got %b expected %b", c, alu_rdy, exp_alu_rdy); end
            tests++; if (wr_inc !== exp_wr) begin fails++; $display("FAIL rand_wr_inc c%0d: got %b expected %b", c, wr_inc, exp_wr); end
            tests++; if (wr_data !== exp_byte) begin fails++; $display("FAIL rand_wr_data c%0d: got %h expected %h", c, wr_data, exp_byte); end
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, exp_busy); end
            if (exp_wr) void'(exp_q.pop_front());
            reg_done = exp_reg_rdy;
            alu_done = exp_alu_rdy;
            if (exp_reg_rdy) begin
                exp_q.push_back(reg_data);
                last_was_reg = 1'b1;
            end
            if (exp_alu_rdy) begin
                two_bytes = 1'b1;
`ifdef ALU_HI_SKIP_EN
                if (alu_data[15:8] == 8'h00) two_bytes = 1'b0;
`endif
                exp_q.push_back(alu_data[7:0]);
                if (two_bytes) exp_q.push_back(alu_data[15:8]);
                last_was_reg = 1'b0;
            end
            next_cycle();
        end
        reg_vld = 1'b0; alu_vld = 1'b0; fifo_full = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_reg_only();
        test_alu();
        test_contention();
        test_backpressure();
        test_skip();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_resp_arbiter.md
TX_RESP_ARBITER -- requirements
Module: tx_resp_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 8, byte width of TX FIFO write data; ALU result width is 2*DATA_W.
REQ-002 SHALL have port: CLK  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: REG_VLD  input  1  register-read response request.
REQ-005 SHALL have port: REG_DATA  input  DATA_W  register-read response byte.
REQ-006 SHALL have port: REG_RDY  output  1  register request accepted this cycle.
REQ-007 SHALL have port: ALU_VLD  input  1  ALU result request.
REQ-008 SHALL have port: ALU_DATA  input  2*DATA_W  ALU result.
REQ-009 SHALL have port: ALU_RDY  output  1  ALU request accepted this cycle.
REQ-010 SHALL have port: FIFO_FULL  input  1  TX FIFO full; no write permitted while high.
REQ-011 SHALL have port: WR_DATA  output  DATA_W  byte written to TX FIFO.
REQ-012 SHALL have port: WR_INC  output  1  one-cycle FIFO write strobe.
REQ-013 SHALL have port: BUSY  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, SEND_REG, SEND_LO, SEND_HI.
REQ-015 SHALL keep a request pending until its RDY is asserted; the requester holds VLD and data stable until then.
REQ-016 In IDLE, SHALL accept at most one request per cycle: REG_RDY or ALU_RDY is high for exactly one cycle, combinationally, in the cycle of acceptance.
REQ-017 SHALL resolve simultaneous REG_VLD and ALU_VLD with a 1-bit round-robin pointer; the pointer favours the requester not granted most recently.
REQ-018 On acceptance, SHALL capture the data into a holding register; transitions IDLE->SEND_REG (reg) or IDLE->SEND_LO (ALU).
REQ-019 In SEND_*, SHALL assert WR_INC only when FIFO_FULL is low; while FIFO_FULL is high SHALL hold state and holding data, with WR_INC low.
REQ-020 SEND_REG: WR_DATA = captured byte; after the write, SHALL go to IDLE.
REQ-021 SEND_LO: WR_DATA = ALU[DATA_W-1:0]; after the write, SHALL go to SEND_HI (see REQ-029). SEND_HI: WR_DATA = ALU[2*DATA_W-1:DATA_W]; after the write, SHALL go to IDLE.
REQ-022 ALU bytes SHALL never be interleaved with a register byte; an accepted ALU frame completes before the next grant.
REQ-023 Minimum latency SHALL be: VLD high in IDLE at cycle N -> RDY at N -> WR_INC at N+1 (reg) or at N+1 and N+2 (ALU).
REQ-024 No request SHALL be accepted in the cycle WR_INC completes a frame; the next grant is no earlier than the following cycle.
REQ-025 WR_DATA SHALL be 0 whenever WR_INC is low.

Reset
REQ-026 While RST is low at a clock edge, SHALL set: state IDLE, pointer favouring REG, holding register 0, WR_INC 0, WR_DATA 0, BUSY 0, REG_RDY 0, ALU_RDY 0.
REQ-027 Reset mid-frame SHALL discard any unwritten bytes; no WR_INC in the cycle after the reset edge.

Configuration
REQ-028 SHALL use macro ALU_HI_SKIP_EN.
REQ-029 With ALU_HI_SKIP_EN defined: if the captured ALU[2*DATA_W-1:DATA_W]==0, SEND_LO SHALL go to IDLE after its write (1-byte frame). Undefined: ALU frames are always 2 bytes.

Structure
REQ-030 The shared package SHALL hold the state encoding type and the byte-count constants.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arb2, with inputs req[1:0] and update, and output gnt[1:0].

Verification
REQ-032 Reg only: REG_VLD with REG_DATA=0x5A, FIFO not full -> REG_RDY same cycle; next cycle WR_INC=1 with WR_DATA=0x5A; then IDLE.
REQ-033 ALU: ALU_DATA=0x1234 -> WR_INC on 2 consecutive cycles, data 0x34 then 0x12.
REQ-034 Contention: both VLD held after reset -> grants REG, ALU, REG alternating; byte order 0x5A, 0x34, 0x12, 0x5A.
REQ-035 Backpressure: FIFO_FULL high for 3 cycles during SEND_HI -> no WR_INC for those cycles; 0x12 is written in the first cycle FIFO_FULL is low.
REQ-036 Skip: ALU_DATA=0x0007 -> with ALU_HI_SKIP_EN defined, one write of 0x07; undefined, writes 0x07 then 0x00.
REQ-037 Reset: RST low during SEND_HI -> IDLE, no further WR_INC, REG favoured on the next contention.
